// File: rtl/pc_redirect_fetch.sv
// PC sequencer and single-outstanding instruction fetch front end with redirect/flush.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets (misalign_o, HALT).
module pc_redirect_fetch #(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            misalign_o,
`endif
  input  logic            if_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HALT
  } state_e;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_INC     = PC_W'(4);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_instr_q, out_instr_d;

  logic            out_free;
  logic            req;
  logic            redirect_act;
  logic [PC_W-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
  logic            unused_pc_bits;

  assign target         = redirect_pc_i[PC_W-1:0];
  assign unused_pc_bits = ^redirect_pc_i[31:PC_W];
`else
  logic            unused_pc_bits;

  assign target         = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign unused_pc_bits = ^{redirect_pc_i[31:PC_W], redirect_pc_i[1:0]};
`endif

  // A halted front end ignores redirects; only reset brings it back.
  assign redirect_act = redirect_i && (state_q != S_HALT);
  assign out_free     = !valid_q || if_ready_i;
  assign req          = (state_q == S_FETCH) && out_free && !redirect_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    valid_d     = valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif

    if (valid_q && if_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (req && imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_FETCH;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_act) begin
            valid_d     = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_rdata_i;
            pc_d        = pc_q + PC_INC;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above; a still-pending response gets marked for drop.
    if (redirect_act) begin
      pc_d    = target;
      valid_d = 1'b0;
      if ((state_q == S_WAIT) && !imem_rvalid_i) begin
        kill_d = 1'b1;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
        kill_d     = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC_V;
      kill_q      <= 1'b0;
      valid_q     <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      valid_q     <= valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = valid_q;
  assign if_pc_o     = out_pc_q;
  assign if_instr_o  = out_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_pc_redirect_fetch.sv
// Bench for pc_redirect_fetch: directed cycle table, hand-written corner sequences and
// randomized traffic against a transaction-level model. Honours FETCH_MISALIGN_CHECK_EN.
module tb_pc_redirect_fetch;

  localparam int PcW = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect;
  logic [31:0]     redirectPc;
  logic            imemReq;
  logic [PcW-1:0]  imemAddr;
  logic            imemGnt;
  logic            imemRvalid;
  logic [31:0]     imemRdata;
  logic            ifValid;
  logic [PcW-1:0]  ifPc;
  logic [31:0]     ifInstr;
  logic            ifReady;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  pc_redirect_fetch #(.PC_W(PcW), .RESET_PC(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .imem_req_o    (imemReq),
    .imem_addr_o   (imemAddr),
    .imem_gnt_i    (imemGnt),
    .imem_rvalid_i (imemRvalid),
    .imem_rdata_i  (imemRdata),
    .if_valid_o    (ifValid),
    .if_pc_o       (ifPc),
    .if_instr_o    (ifInstr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_o    (misalign),
`endif
    .if_ready_i    (ifReady)
  );

  typedef struct {
    logic           redir;
    logic [31:0]    rpc;
    logic           gnt;
    logic           rvalid;
    logic [31:0]    rdata;
    logic           ready;
    logic           eReq;
    logic [PcW-1:0] eAddr;
    logic           eValid;
    logic [PcW-1:0] ePc;
    logic [31:0]    eInstr;
  } vec_t;

  vec_t vecs[$];

  // Memory contents: the address tagged into a recognisable pattern.
  function automatic logic [31:0] memWord(input int addr);
    return 32'hC0DE_0000 | (addr & 32'h1FF);
  endfunction

  function automatic vec_t mkVec(input logic redir, input logic [31:0] rpc, input logic gnt,
                                 input logic rvalid, input logic [31:0] rdata, input logic ready,
                                 input logic eReq, input logic [PcW-1:0] eAddr, input logic eValid,
                                 input logic [PcW-1:0] ePc, input logic [31:0] eInstr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    v.ready = ready; v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
    v.ePc = ePc; v.eInstr = eInstr;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic gnt,
                               input logic rvalid, input logic [31:0] rdata, input logic ready);
    redirect   = redir;
    redirectPc = rpc;
    imemGnt    = gnt;
    imemRvalid = rvalid;
    imemRdata  = rdata;
    ifReady    = ready;
  endtask

  task automatic checkOutput(input string tag, input logic eReq, input logic [PcW-1:0] eAddr,
                             input logic eValid, input logic [PcW-1:0] ePc,
                             input logic [31:0] eInstr, input logic checkData);
    checkEq({tag, ".req"}, 32'(imemReq), 32'(eReq));
    checkEq({tag, ".addr"}, 32'(imemAddr), 32'(eAddr));
    checkEq({tag, ".valid"}, 32'(ifValid), 32'(eValid));
    if (checkData) begin
      checkEq({tag, ".pc"}, 32'(ifPc), 32'(ePc));
      checkEq({tag, ".instr"}, ifInstr, eInstr);
    end
  endtask

  // Enters at posedge+1, leaves at posedge+1 with reset released (the IDLE cycle follows).
  task automatic doReset();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0, 0, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkEq("reset.misalign", 32'(misalign), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Transaction-level reference model state.
  bit          mStarted, mWait, mStale, mValid, mHalt, mMis;
  int          mPc, mOutPc;
  logic [31:0] mOutInstr;
  bit          memBusy;
  int          memCnt, memAddr;

  initial begin
    vec_t v;
    logic rRedir, rGnt, rRvalid, rReady, expReq, xfer;
    logic [31:0] rPc, rData;
    int target;

    // Zero-wait fetch, stall, redirect in WAIT / with rvalid / with stalled output, wrap.
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 1,                  0, 9'h000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(0), 1,         0, 9'h000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h004, 1, 9'h000, memWord(0)));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(4), 1,         0, 9'h004, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(0, 0, 1, 0, 0, 0,                0, 9'h008, 1, 9'h004, memWord(4)));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h008, 1, 9'h004, memWord(4)));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(8), 1,         0, 9'h008, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 1,                  1, 9'h00C, 1, 9'h008, memWord(8)));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h00C, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(12), 1,        0, 9'h00C, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h010, 1, 9'h00C, memWord(12)));
    vecs.push_back(mkVec(1, 32'h40, 0, 0, 0, 1,             0, 9'h010, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(16), 1,        0, 9'h040, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h040, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(32'h40), 1,    0, 9'h040, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0,                  0, 9'h044, 1, 9'h040, memWord(32'h40)));
    vecs.push_back(mkVec(1, 32'hFFFF_FE80, 0, 0, 0, 0,      0, 9'h044, 1, 9'h040, memWord(32'h40)));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h080, 0, 0, 0));
    vecs.push_back(mkVec(1, 32'h1FC, 0, 1, memWord(32'h80), 1, 0, 9'h080, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h1FC, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(32'h1FC), 1,   0, 9'h1FC, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 1,                  1, 9'h000, 1, 9'h1FC, memWord(32'h1FC)));
    vecs.push_back(mkVec(0, 0, 0, 1, memWord(0), 1,         0, 9'h000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 1,                  1, 9'h004, 1, 9'h000, memWord(0)));

    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.redir, v.rpc, v.gnt, v.rvalid, v.rdata, v.ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), v.eReq, v.eAddr, v.eValid, v.ePc, v.eInstr, v.eValid);
      @(posedge clk); #1;
    end

    // Misaligned redirect to 0x42 issued in FETCH with gnt high.
    applyStimulus(1, 32'h42, 1, 0, 0, 1);
    @(negedge clk);
    checkOutput("misRedir", 0, 9'h004, 0, 0, 0, 0);
    @(posedge clk); #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 1);
      @(negedge clk);
      checkEq($sformatf("halt%0d.misalign", i), 32'(misalign), 1);
      checkEq($sformatf("halt%0d.req", i), 32'(imemReq), 0);
      checkEq($sformatf("halt%0d.valid", i), 32'(ifValid), 0);
      @(posedge clk); #1;
    end
`else
    applyStimulus(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    checkOutput("misFetch", 1, 9'h040, 0, 0, 0, 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 1, memWord(32'h40), 1);
    @(negedge clk);
    checkOutput("misWait", 0, 9'h040, 0, 0, 0, 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("misLoad", 0, 9'h044, 1, 9'h040, memWord(32'h40), 1);
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    checkOutput("preWait", 1, 9'h044, 1, 9'h040, memWord(32'h40), 1);
    @(posedge clk); #1;
`endif

    // Asynchronous reset mid-cycle (mid-WAIT in the default build) must act immediately.
    applyStimulus(0, 0, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncRst", 0, 0, 0, 0, 0, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkEq("asyncRst.misalign", 32'(misalign), 0);
`endif
    @(posedge clk); #1;
    doReset();

    // Randomized traffic against the model.
    mStarted = 0; mWait = 0; mStale = 0; mValid = 0; mHalt = 0; mMis = 0;
    mPc = 0; mOutPc = 0; mOutInstr = 0;
    memBusy = 0; memCnt = 0; memAddr = 0;
    for (int c = 0; c < 2000; c++) begin
      rRedir = ($urandom_range(0, 7) == 0);
      rPc    = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      rPc[1:0] = 2'b00;
`endif
      rReady  = ($urandom_range(0, 3) != 0);
      rGnt    = ($urandom_range(0, 2) != 0);
      rRvalid = memBusy && (memCnt == 0);
      rData   = rRvalid ? memWord(memAddr) : $urandom;
      applyStimulus(rRedir, rPc, rGnt, rRvalid, rData, rReady);
      expReq = mStarted && !mHalt && !mWait && (!mValid || rReady) && !rRedir;
      @(negedge clk);
      checkOutput($sformatf("rnd%0d", c), expReq, mPc[PcW-1:0], mValid,
                  mOutPc[PcW-1:0], mOutInstr, mValid);
`ifdef FETCH_MISALIGN_CHECK_EN
      checkEq($sformatf("rnd%0d.misalign", c), 32'(misalign), 32'(mMis));
`endif
      // Memory: one response per grant after 0..2 idle cycles.
      if (rRvalid) memBusy = 0;
      else if (memBusy) memCnt--;
      if (imemReq && rGnt) begin
        memBusy = 1;
        memCnt  = $urandom_range(0, 2);
        memAddr = int'(imemAddr);
      end
      xfer = mValid && rReady;
      if (mHalt) begin
      end else if (rRedir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        target = int'(rPc & 32'h1FF);
        if (rPc[1:0] != 2'b00) begin mHalt = 1; mMis = 1; end
`else
        target = int'(rPc & 32'h1FC);
`endif
        mPc = target;
        mValid = 0;
        mStarted = 1;
        if (mWait) begin
          if (rRvalid) begin mWait = 0; mStale = 0; end
          else mStale = 1;
        end
      end else begin
        if (xfer) mValid = 0;
        if (!mStarted) mStarted = 1;
        else if (mWait) begin
          if (rRvalid) begin
            mWait = 0;
            if (mStale) mStale = 0;
            else begin
              mValid = 1; mOutPc = mPc; mOutInstr = rData;
              mPc = (mPc + 4) % 512;
            end
          end
        end else if (expReq && rGnt) mWait = 1;
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_redirect_fetch.md
Name: pc_redirect_fetch

Overview:
- PC register and instruction-fetch front end that consumes the branch-resolution outputs: the taken flag (PcSel) and the target (BrPC).
- Sequences the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Delivers {pc, instr} to the IF/ID stage over a valid/ready handshake.
- Flushes in-flight and buffered fetches when a redirect arrives.

Parameters:
- PC_W, 9, PC width in bits; all PC arithmetic is modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_i  in  1  branch/jump taken (PcSel from branch resolution).
- redirect_pc_i  in  32  redirect target (BrPC); only bits [PC_W-1:0] are used.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_W  fetch address.
- imem_gnt_i  in  1  request accepted in this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  output register holds a valid instruction.
- if_pc_o  out  PC_W  PC of the held instruction.
- if_instr_o  out  32  held instruction.
- if_ready_i  in  1  IF/ID accepts in this cycle.

Behaviour:
- Reset asserted (at any time, including mid-transaction):
  - state=IDLE, pc=RESET_PC, kill=0.
  - if_valid_o=0, if_pc_o=0, if_instr_o=0, imem_req_o=0, imem_addr_o=RESET_PC.
- out_free = !if_valid_o || if_ready_i.
- Output transfer occurs when if_valid_o && if_ready_i.
- FSM states:
  - IDLE: one cycle after reset release, no request -> FETCH.
  - FETCH:
    - imem_req_o = out_free && !redirect_i; imem_addr_o=pc.
    - Address is held stable while req=1 and gnt=0.
    - req && gnt -> WAIT.
  - WAIT:
    - imem_req_o=0; at most one request is outstanding.
    - rvalid with kill=0: output register loads {pc, rdata}, if_valid_o=1, pc <= pc+4, -> FETCH.
    - rvalid with kill=1: data is discarded, kill<=0, -> FETCH; pc is not advanced.
- if_valid_o clears on a transfer with no simultaneous load.
- A load into the output register is only possible when out_free held at issue time, so no overwrite of an untransferred instruction occurs.
- Redirect (redirect_i=1) always has priority over all other events in that cycle:
  - pc <= redirect_pc_i[PC_W-1:0].
  - if_valid_o <= 0 (flush), regardless of if_ready_i.
  - In WAIT without rvalid: kill <= 1; the next rvalid is dropped.
  - Redirect with rvalid in the same cycle: rdata is dropped, no load, -> FETCH with the new pc.
  - In FETCH: imem_req_o=0 that cycle, so no stale request is granted.
  - Back-to-back redirects: the last target wins.
- Wrap-around: pc+4 past 2^PC_W-4 wraps to 0 silently.
- Latency with zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - request at cycle N, if_valid_o=1 at N+2.
  - Steady-state throughput is one instruction per 2 cycles while if_ready_i=1.
- Stall: if_ready_i=0 with if_valid_o=1 blocks new requests; the output register holds its value.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1 and moves the FSM to a HALT state.
  - HALT: no requests, if_valid_o=0; exit only by reset.
  - Any response already in flight is consumed and discarded.
- When undefined:
  - No port.
  - Low two target bits are forced to 0: pc <= {redirect_pc_i[PC_W-1:2], 2'b00}.

Test Plan:
- Reset release, zero-wait memory, if_ready_i=1: addresses 0,4,8 are issued; if_pc_o=0,4,8 with the matching rdata; first if_valid_o 2 cycles after the first request.
- Stall: hold if_ready_i=0 for 5 cycles while if_valid_o=1 at pc=4: imem_req_o=0 throughout, if_instr_o stable; after release, the next request is at address 8.
- Redirect during WAIT (request at 0x10, redirect to 0x40 before rvalid): the returning word is dropped, if_valid_o stays 0, next request is at 0x40, then if_pc_o=0x40.
- Redirect in the same cycle as rvalid, and redirect with if_valid_o=1 and if_ready_i=0: no load / immediate flush; next fetch is at the target.
- Wrap: PC_W=9, redirect to 0x1FC: fetches 0x1FC then 0x000.
- Misaligned redirect to 0x42: with FETCH_MISALIGN_CHECK_EN, misalign_o=1 and no further requests; without it, the next fetch is at 0x40. Async reset asserted mid-WAIT returns all outputs to reset values immediately.
